// File: rtl/sonic_obstacle_guard.sv
// sonic_obstacle_guard
//   Turns the 6-bit centimetre reading from the ultrasonic ranger into a
//   stop/go decision for the motor and steering controller. Readings are
//   taken at a fixed rate. Zero (no echo) readings are rejected. Accepted
//   readings are averaged over a sliding window. A hysteresis FSM with
//   N-sample confirmation then drives `stop`. A run of zero readings raises
//   `fault` and forces the car to halt.
module sonic_obstacle_guard #(
   parameter int SAMPLE_DIV  = 5_000_000, // clk cycles between samples, >= 2
   parameter int LOG2_DEPTH  = 2,         // window depth = 2**LOG2_DEPTH (1..3)
   parameter int NEAR_CM     = 15,        // avg below this is "near"
   parameter int FAR_CM      = 20,        // avg at or above this is "far"
   parameter int CONFIRM     = 3,         // qualifying averages to change state (1..15)
   parameter int INVALID_MAX = 4          // consecutive zero samples that raise fault (1..15)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] distance,
   output logic [5:0] avg_dist,
   output logic       valid,
   output logic       stop,
   output logic       fault
);

   localparam int                  DEPTH        = 1 << LOG2_DEPTH;
   localparam int                  DIV_W        = $clog2(SAMPLE_DIV);
   localparam logic [DIV_W-1:0]    DIV_LAST     = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [DIV_W-1:0]    DIV_ONE      = DIV_W'(1);
   localparam logic [LOG2_DEPTH:0] FILL_FULL    = {1'b1, {LOG2_DEPTH{1'b0}}};
   localparam logic [LOG2_DEPTH:0] FILL_ONE     = {{LOG2_DEPTH{1'b0}}, 1'b1};
   localparam logic [LOG2_DEPTH-1:0] PTR_ONE    = {{(LOG2_DEPTH-1){1'b0}}, 1'b1};
   localparam logic [5:0]          NEAR_C       = 6'(NEAR_CM);
   localparam logic [5:0]          FAR_C        = 6'(FAR_CM);
   localparam logic [3:0]          CONFIRM_LAST = 4'(CONFIRM - 1);
   localparam logic [3:0]          INV_MAX_C    = 4'(INVALID_MAX);
   localparam logic [3:0]          INV_LAST     = 4'(INVALID_MAX - 1);

   typedef enum logic [0:0] {
      ST_CLEAR   = 1'b0,
      ST_BLOCKED = 1'b1
   } state_t;

   // Sample timing
   logic [DIV_W-1:0]      div_r;
   logic                  sample_en_s;

   // Sample classification
   logic                  sample_zero_s;
   logic                  accept_s;
   logic                  fault_entry_s;

   // Sliding window
   logic [5:0]            win_r [DEPTH];
   logic [LOG2_DEPTH-1:0] wr_ptr_r;
   logic [LOG2_DEPTH:0]   fill_r;
   logic [8:0]            sum_r;
   logic                  full_s;
   logic [8:0]            evict_s;
   logic [8:0]            sum_nx_s;

   // Sensor health
   logic [3:0]            zero_cnt_r;
   logic                  fault_r;

   // Averaging stage
   logic                  accept_r;
   logic [5:0]            avg_r;
   logic                  valid_r;
   logic                  avg_upd_r;

   // Decision FSM
   state_t                state_r;
   state_t                state_nx_s;
   logic [3:0]            cnt_r;
   logic [3:0]            cnt_nx_s;
   logic                  stop_r;

   // Free-running sample divider, terminal count produces the sample strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_r <= '0;
      end else if (div_r == DIV_LAST) begin
         div_r <= '0;
      end else begin
         div_r <= div_r + DIV_ONE;
      end
   end

   assign sample_en_s = (div_r == DIV_LAST);

   // Classify the reading captured at this strobe and prepare the running-sum update.
   always_comb begin
      sample_zero_s = 1'b0;
      accept_s      = 1'b0;
      fault_entry_s = 1'b0;
      full_s        = (fill_r == FILL_FULL);
      evict_s       = 9'd0;
      if (sample_en_s) begin
         sample_zero_s = (distance == 6'd0);
         accept_s      = (distance != 6'd0);
         // The run reaches its limit on this zero (or is already saturated there).
         fault_entry_s = (distance == 6'd0) && (zero_cnt_r >= INV_LAST);
      end else begin
         sample_zero_s = 1'b0;
         accept_s      = 1'b0;
         fault_entry_s = 1'b0;
      end
      // Until the window has filled, the slot being overwritten holds nothing
      // that is part of the sum (it may hold stale data after a flush).
      if (full_s) begin
         evict_s = {3'b000, win_r[wr_ptr_r]};
      end else begin
         evict_s = 9'd0;
      end
      // 63 * 8 = 504 fits in 9 bits, so this never wraps.
      sum_nx_s = sum_r - evict_s + {3'b000, distance};
   end

   // Zero-run counter: counts consecutive invalid readings, saturating at the limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         zero_cnt_r <= 4'd0;
      end else if (sample_zero_s) begin
         if (zero_cnt_r != INV_MAX_C) begin
            zero_cnt_r <= zero_cnt_r + 4'd1;
         end
      end else if (accept_s) begin
         zero_cnt_r <= 4'd0;
      end
   end

   // Fault flag: raised when the zero run hits the limit, cleared by any valid reading.
   always_ff @(posedge clk) begin
      if (rst) begin
         fault_r <= 1'b0;
      end else if (fault_entry_s) begin
         fault_r <= 1'b1;
      end else if (accept_s) begin
         fault_r <= 1'b0;
      end
   end

   // Window storage, write pointer, fill count and running sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            win_r[i] <= 6'd0;
         end
         wr_ptr_r <= '0;
         fill_r   <= '0;
         sum_r    <= 9'd0;
      end else if (fault_entry_s) begin
         // Flush: buffer contents and pointer are left alone; the fill count
         // masks them out of the sum until they are overwritten.
         fill_r <= '0;
         sum_r  <= 9'd0;
      end else if (accept_s) begin
         win_r[wr_ptr_r] <= distance;
         wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         sum_r           <= sum_nx_s;
         if (!full_s) begin
            fill_r <= fill_r + FILL_ONE;
         end
      end
   end

   // Remember that a reading was accepted so the average follows one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         accept_r <= 1'b0;
      end else begin
         accept_r <= accept_s;
      end
   end

   // Average stage: publish sum/DEPTH once the window is full; avg holds otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         avg_r     <= 6'd0;
         valid_r   <= 1'b0;
         avg_upd_r <= 1'b0;
      end else if (fault_entry_s) begin
         valid_r   <= 1'b0;
         avg_upd_r <= 1'b0;
      end else if (accept_r) begin
         valid_r   <= full_s;
         avg_upd_r <= 1'b1;
         if (full_s) begin
            avg_r <= sum_r[LOG2_DEPTH +: 6];
         end
      end else begin
         avg_upd_r <= 1'b0;
      end
   end

   // Decision FSM next state: hysteresis with consecutive-average confirmation.
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      if (fault_entry_s) begin
         state_nx_s = ST_BLOCKED;
         cnt_nx_s   = 4'd0;
      end else if (avg_upd_r && valid_r) begin
         case (state_r)
            ST_CLEAR: begin
               if (avg_r < NEAR_C) begin
                  if (cnt_r == CONFIRM_LAST) begin
                     state_nx_s = ST_BLOCKED;
                     cnt_nx_s   = 4'd0;
                  end else begin
                     cnt_nx_s = cnt_r + 4'd1;
                  end
               end else begin
                  cnt_nx_s = 4'd0;
               end
            end
            ST_BLOCKED: begin
               if (avg_r >= FAR_C) begin
                  if (cnt_r == CONFIRM_LAST) begin
                     state_nx_s = ST_CLEAR;
                     cnt_nx_s   = 4'd0;
                  end else begin
                     cnt_nx_s = cnt_r + 4'd1;
                  end
               end else begin
                  cnt_nx_s = 4'd0;
               end
            end
            default: begin
               state_nx_s = ST_BLOCKED;
               cnt_nx_s   = 4'd0;
            end
         endcase
      end else begin
         state_nx_s = state_r;
         cnt_nx_s   = cnt_r;
      end
   end

   // Decision FSM state, confirmation counter and registered stop output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_BLOCKED;
         cnt_r   <= 4'd0;
         stop_r  <= 1'b1;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
         // valid only drops on fault entry, which also forces BLOCKED, and the
         // FSM can only leave BLOCKED on a valid average, so following the
         // state keeps stop high whenever valid=0 or fault=1.
         stop_r  <= (state_nx_s == ST_BLOCKED) || fault_entry_s;
      end
   end

   assign avg_dist = avg_r;
   assign valid    = valid_r;
   assign stop     = stop_r;
   assign fault    = fault_r;

endmodule

// File: tb/tb_sonic_obstacle_guard.sv
// Scoreboard bench for sonic_obstacle_guard with SAMPLE_DIV=4, depth 4,
// NEAR=15, FAR=20, CONFIRM=3, INVALID_MAX=4. Stimulus pushes hand-computed
// expectations, tagged with the bench cycle at which they become due; an
// independent monitor pops and compares them.
module tb_sonic_obstacle_guard;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] distance;
   logic [5:0] avg_dist;
   logic       valid;
   logic       stop;
   logic       fault;

   typedef struct {
      int         due;
      int         tst;
      int         idx;
      logic [5:0] avg;
      logic       v;
      logic       s;
      logic       f;
   } exp_t;

   exp_t sb_q[$];
   int   cyc;
   int   checks = 0;
   int   errors = 0;
   int   tst    = 0;
   int   idx    = 0;

   sonic_obstacle_guard #(
      .SAMPLE_DIV (4),
      .LOG2_DEPTH (2),
      .NEAR_CM    (15),
      .FAR_CM     (20),
      .CONFIRM    (3),
      .INVALID_MAX(4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .distance(distance),
      .avg_dist(avg_dist),
      .valid   (valid),
      .stop    (stop),
      .fault   (fault)
   );

   always #5 clk = ~clk;

   // Bench cycle count since the last reset edge; sample edges fall on multiples of 4.
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic chk(input int t, input int i, input string what,
                      input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL t%0d#%0d %s: got %0d expected %0d", t, i, what, act, exp);
      end
   endtask

   task automatic push_exp(input int due, input logic [5:0] a,
                           input logic v, input logic s, input logic f);
      exp_t e;
      e.due = due; e.tst = tst; e.idx = idx;
      e.avg = a; e.v = v; e.s = s; e.f = f;
      sb_q.push_back(e);
      idx++;
   endtask

   // Called at the negedge just after a sample-aligned edge: the reading is
   // captured 4 edges later and outputs have settled 2 edges after that.
   task automatic do_sample(input logic [5:0] d, input logic [5:0] a,
                            input logic v, input logic s, input logic f);
      distance = d;
      push_exp(cyc + 6, a, v, s, f);
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 16 && sb_q.size() != 0; i++) repeat (4) @(negedge clk);
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   // Monitor: compares every expectation whose due cycle has arrived.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            if (e.due < cyc) begin
               checks++;
               errors++;
               $display("FAIL t%0d#%0d timing: got cycle %0d expected cycle %0d",
                        e.tst, e.idx, cyc, e.due);
            end else begin
               chk(e.tst, e.idx, "avg_dist", {2'b00, avg_dist}, {2'b00, e.avg});
               chk(e.tst, e.idx, "valid",    {7'd0, valid},     {7'd0, e.v});
               chk(e.tst, e.idx, "stop",     {7'd0, stop},      {7'd0, e.s});
               chk(e.tst, e.idx, "fault",    {7'd0, fault},     {7'd0, e.f});
            end
         end
      end
   end

   // Watchdog so the run always ends with a summary.
   initial begin
      #100000;
      errors++;
      checks++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      rst      = 1'b1;
      distance = 6'd0;
      repeat (3) @(negedge clk);

      // 1: reset state, then constant 30 fills the window and clears stop
      tst = 1; idx = 0;
      push_exp(cyc, 6'd0, 1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      do_sample(6'd30, 6'd0,  1'b0, 1'b1, 1'b0);
      do_sample(6'd30, 6'd0,  1'b0, 1'b1, 1'b0);
      do_sample(6'd30, 6'd0,  1'b0, 1'b1, 1'b0);
      do_sample(6'd30, 6'd30, 1'b1, 1'b1, 1'b0);
      do_sample(6'd30, 6'd30, 1'b1, 1'b1, 1'b0);
      do_sample(6'd30, 6'd30, 1'b1, 1'b0, 1'b0);

      // 2: step to 10; 15 is dead band, stop after the 6th sample
      tst = 2; idx = 0;
      do_sample(6'd10, 6'd25, 1'b1, 1'b0, 1'b0);
      do_sample(6'd10, 6'd20, 1'b1, 1'b0, 1'b0);
      do_sample(6'd10, 6'd15, 1'b1, 1'b0, 1'b0);
      do_sample(6'd10, 6'd10, 1'b1, 1'b0, 1'b0);
      do_sample(6'd10, 6'd10, 1'b1, 1'b0, 1'b0);
      do_sample(6'd10, 6'd10, 1'b1, 1'b1, 1'b0);
      // back to 30: 15 dead band, 20 counts as far
      do_sample(6'd30, 6'd15, 1'b1, 1'b1, 1'b0);
      do_sample(6'd30, 6'd20, 1'b1, 1'b1, 1'b0);
      do_sample(6'd30, 6'd25, 1'b1, 1'b1, 1'b0);
      do_sample(6'd30, 6'd30, 1'b1, 1'b0, 1'b0);

      // 3: alternate 14/22, average settles at 18, stop never rises
      tst = 3; idx = 0;
      do_sample(6'd14, 6'd26, 1'b1, 1'b0, 1'b0);
      do_sample(6'd22, 6'd24, 1'b1, 1'b0, 1'b0);
      do_sample(6'd14, 6'd20, 1'b1, 1'b0, 1'b0);
      do_sample(6'd22, 6'd18, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         do_sample(6'd14, 6'd18, 1'b1, 1'b0, 1'b0);
         do_sample(6'd22, 6'd18, 1'b1, 1'b0, 1'b0);
      end
      do_sample(6'd30, 6'd22, 1'b1, 1'b0, 1'b0);
      do_sample(6'd30, 6'd24, 1'b1, 1'b0, 1'b0);
      do_sample(6'd30, 6'd28, 1'b1, 1'b0, 1'b0);
      do_sample(6'd30, 6'd30, 1'b1, 1'b0, 1'b0);

      // 4: four zeros raise fault and flush; recovery refills then clears
      tst = 4; idx = 0;
      do_sample(6'd0,  6'd30, 1'b1, 1'b0, 1'b0);
      do_sample(6'd0,  6'd30, 1'b1, 1'b0, 1'b0);
      do_sample(6'd0,  6'd30, 1'b1, 1'b0, 1'b0);
      do_sample(6'd0,  6'd30, 1'b0, 1'b1, 1'b1);
      do_sample(6'd30, 6'd30, 1'b0, 1'b1, 1'b0);
      do_sample(6'd30, 6'd30, 1'b0, 1'b1, 1'b0);
      do_sample(6'd30, 6'd30, 1'b0, 1'b1, 1'b0);
      do_sample(6'd30, 6'd30, 1'b1, 1'b1, 1'b0);
      do_sample(6'd30, 6'd30, 1'b1, 1'b1, 1'b0);
      do_sample(6'd30, 6'd30, 1'b1, 1'b0, 1'b0);

      // 5: runs of three zeros never fault and leave the average alone
      tst = 5; idx = 0;
      for (int r = 0; r < 2; r++) begin
         for (int z = 0; z < 3; z++) do_sample(6'd0, 6'd30, 1'b1, 1'b0, 1'b0);
         do_sample(6'd30, 6'd30, 1'b1, 1'b0, 1'b0);
      end

      // 6: one-cycle reset coincident with the sample strobe drops the sample
      wait_drain();
      tst = 6; idx = 0;
      distance = 6'd50;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      push_exp(cyc, 6'd0, 1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      do_sample(6'd40, 6'd0,  1'b0, 1'b1, 1'b0);
      do_sample(6'd40, 6'd0,  1'b0, 1'b1, 1'b0);
      do_sample(6'd40, 6'd0,  1'b0, 1'b1, 1'b0);
      do_sample(6'd40, 6'd40, 1'b1, 1'b1, 1'b0);
      do_sample(6'd40, 6'd40, 1'b1, 1'b1, 1'b0);
      do_sample(6'd40, 6'd40, 1'b1, 1'b0, 1'b0);

      // 7: truncating average (161/4 -> 40, 164/4 -> 41)
      tst = 7; idx = 0;
      do_sample(6'd41, 6'd40, 1'b1, 1'b0, 1'b0);
      do_sample(6'd43, 6'd41, 1'b1, 1'b0, 1'b0);

      wait_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
